// File: rtl/pcileech_board_ctl_if.sv
// Board-pad side signal bundle for pcileech_board_ctl: buttons, LED controls
// and the status outputs handed to the rest of the PCILeech design.
interface pcileech_board_ctl_if #(
  parameter int NUM_BTN = 2,
  parameter int NUM_LED = 2
);

  logic [NUM_BTN-1:0]   btn_n;
  logic [NUM_LED-1:0]   led_act;
  logic [2*NUM_LED-1:0] led_mode;
  logic [NUM_LED-1:0]   led_invert;
  logic [63:0]          tickcount64;
  logic                 rst_out;
  logic [NUM_BTN-1:0]   btn_pressed;
  logic [NUM_BTN-1:0]   btn_long;
  logic [NUM_LED-1:0]   led_n;

  // Board / top-level side: drives pads and LED requests, observes status.
  modport master (
    output btn_n,
    output led_act,
    output led_mode,
    output led_invert,
    input  tickcount64,
    input  rst_out,
    input  btn_pressed,
    input  btn_long,
    input  led_n
  );

  // Board-control block side.
  modport slave (
    input  btn_n,
    input  led_act,
    input  led_mode,
    input  led_invert,
    output tickcount64,
    output rst_out,
    output btn_pressed,
    output btn_long,
    output led_n
  );

endinterface

// File: rtl/pcileech_board_ctl.sv
// Board-control block shared by the PCILeech top modules: free-running tick
// counter, stretched system reset, per-button synchronise/debounce/long-press
// detection and per-LED mode driver with activity stretching and a power-on
// blink overlay on LED 0.
module pcileech_board_ctl #(
  parameter int NUM_BTN          = 2,
  parameter int NUM_LED          = 2,
  parameter int RST_BTN          = 1,
  parameter int DEBOUNCE_CYCLES  = 1000000,
  parameter int LONGPRESS_CYCLES = 500000000,
  parameter int RST_HOLD_CYCLES  = 64,
  parameter int ACT_STRETCH_LOG2 = 22,
  parameter int BLINK_BIT        = 24,
  parameter int PWRON_WIN_BIT    = 27
) (
  input  logic                  clk,
  input  logic                  rst,
  pcileech_board_ctl_if.slave   bus
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int LP_W  = $clog2(LONGPRESS_CYCLES + 1);
  localparam int ACT_W = ACT_STRETCH_LOG2;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LP_W-1:0]  LP_MAX   = LP_W'(LONGPRESS_CYCLES);
  localparam logic [LP_W-1:0]  LP_PRE   = LP_W'(LONGPRESS_CYCLES - 1);
  localparam logic [63:0]      HOLD_LIM = 64'(RST_HOLD_CYCLES);

  // Button synchroniser, debounce and long-press state.
  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;
  logic [DB_W-1:0]    db_cnt_q [NUM_BTN];
  logic [DB_W-1:0]    db_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] pressed_q;
  logic [NUM_BTN-1:0] pressed_d;
  logic [LP_W-1:0]    lp_cnt_q [NUM_BTN];
  logic [LP_W-1:0]    lp_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] long_q;
  logic [NUM_BTN-1:0] long_d;

  // Tick counter and reset stretcher.
  logic [63:0]        tick_q;
  logic [63:0]        tick_d;
  logic               rst_out_q;
  logic               rst_out_d;

  // LED activity stretch and mode pipeline.
  logic [ACT_W-1:0]   act_cnt_q [NUM_LED];
  logic [ACT_W-1:0]   act_cnt_d [NUM_LED];
  logic [NUM_LED-1:0] act_on;
  logic [NUM_LED-1:0] on_q;
  logic [NUM_LED-1:0] on_d;
  logic [NUM_LED-1:0] inv_q;
  logic               pwron_q;
  logic               pwron_d;
  logic [NUM_LED-1:0] pwron_mask;

  // Two-flop synchroniser per button; released (1) out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= bus.btn_n;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive samples that disagree with the accepted
  // level; flip the level once DEBOUNCE_CYCLES disagreeing samples are seen.
  always_comb begin
    pressed_d = pressed_q;
    for (int b = 0; b < NUM_BTN; b++) begin
      db_cnt_d[b] = '0;
      // Synced sample is active-low: equal to pressed_q means it disagrees.
      if (sync2_q[b] == pressed_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) begin
          pressed_d[b] = ~pressed_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  // Long press: saturating hold counter, single pulse when it hits the limit.
  always_comb begin
    long_d = '0;
    for (int b = 0; b < NUM_BTN; b++) begin
      lp_cnt_d[b] = '0;
      if (pressed_q[b]) begin
        if (lp_cnt_q[b] != LP_MAX) begin
          lp_cnt_d[b] = lp_cnt_q[b] + 1'b1;
          long_d[b]   = (lp_cnt_q[b] == LP_PRE);
        end else begin
          lp_cnt_d[b] = lp_cnt_q[b];
        end
      end
    end
  end

  // Button state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pressed_q <= '0;
      long_q    <= '0;
      for (int b = 0; b < NUM_BTN; b++) begin
        db_cnt_q[b] <= '0;
        lp_cnt_q[b] <= '0;
      end
    end else begin
      pressed_q <= pressed_d;
      long_q    <= long_d;
      for (int b = 0; b < NUM_BTN; b++) begin
        db_cnt_q[b] <= db_cnt_d[b];
        lp_cnt_q[b] <= lp_cnt_d[b];
      end
    end
  end

  // Tick counter held at zero by the reset button; reset output stays high
  // until the counter has run RST_HOLD_CYCLES past its restart.
  always_comb begin
    tick_d    = pressed_q[RST_BTN] ? 64'd0 : tick_q + 64'd1;
    rst_out_d = pressed_q[RST_BTN] | (tick_q < HOLD_LIM);
  end

  // Tick counter and stretched reset registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q    <= '0;
      rst_out_q <= 1'b1;
    end else begin
      tick_q    <= tick_d;
      rst_out_q <= rst_out_d;
    end
  end

  // Activity stretch: a strobe (re)loads the counter, which then drains to 0.
  always_comb begin
    for (int l = 0; l < NUM_LED; l++) begin
      act_on[l] = bus.led_act[l] | (act_cnt_q[l] != '0);
      if (bus.led_act[l]) begin
        act_cnt_d[l] = '1;
      end else if (act_cnt_q[l] != '0) begin
        act_cnt_d[l] = act_cnt_q[l] - 1'b1;
      end else begin
        act_cnt_d[l] = '0;
      end
    end
  end

  // LED mode select and power-on blink window (LED 0 only).
  always_comb begin
    for (int l = 0; l < NUM_LED; l++) begin
      case (bus.led_mode[2*l +: 2])
        2'b00:   on_d[l] = 1'b0;
        2'b01:   on_d[l] = 1'b1;
        2'b10:   on_d[l] = act_on[l];
        default: on_d[l] = tick_q[BLINK_BIT];
      endcase
    end
    pwron_d = (tick_q[63:PWRON_WIN_BIT] == '0) & tick_q[BLINK_BIT];
  end

  // LED pipeline registers; all-zero state drives every LED dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      on_q    <= '0;
      inv_q   <= '0;
      pwron_q <= 1'b0;
      for (int l = 0; l < NUM_LED; l++) begin
        act_cnt_q[l] <= '0;
      end
    end else begin
      on_q    <= on_d;
      inv_q   <= bus.led_invert;
      pwron_q <= pwron_d;
      for (int l = 0; l < NUM_LED; l++) begin
        act_cnt_q[l] <= act_cnt_d[l];
      end
    end
  end

  // Active-low pad drive; power-on blink overlays LED 0 only.
  always_comb begin
    pwron_mask    = '0;
    pwron_mask[0] = pwron_q;
  end

  assign bus.led_n       = ~(on_q ^ inv_q ^ pwron_mask);
  assign bus.tickcount64 = tick_q;
  assign bus.rst_out     = rst_out_q;
  assign bus.btn_pressed = pressed_q;
  assign bus.btn_long    = long_q;

endmodule
